// File: rtl/rob_pkg.sv
// Shared reorder-buffer sizing, entry type encodings and the per-entry record.
package rob_pkg;

    localparam int ROB_WIDTH = 3;
    localparam int ROB_SIZE  = 1 << ROB_WIDTH;

    localparam logic [1:0] ROB_REG    = 2'd0;
    localparam logic [1:0] ROB_STORE  = 2'd1;
    localparam logic [1:0] ROB_BRANCH = 2'd2;
    localparam logic [1:0] ROB_HALT   = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] val;
        logic        pred_jump;
        logic        jump;
        logic [31:0] target;
    } rob_entry_t;

    function automatic logic [ROB_WIDTH-1:0] rob_next(input logic [ROB_WIDTH-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocate at tail, out-of-order writeback, in-order retire at head.
// Mispredicted branches raise a one-cycle clear; the flush itself happens in that clear cycle.
module rob
    import rob_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,

    input  logic                 issue_valid,
    input  logic [1:0]           issue_type,
    input  logic [4:0]           issue_rd,
    input  logic [31:0]          issue_pc,
    input  logic                 issue_pred_jump,
    input  logic                 issue_done,
    input  logic [31:0]          issue_val,
    output logic                 full,
    output logic [ROB_WIDTH-1:0] issue_rob_id,

    input  logic                 alu_valid,
    input  logic [ROB_WIDTH-1:0] alu_rob_id,
    input  logic [31:0]          alu_val,
    input  logic                 alu_jump,
    input  logic [31:0]          alu_target,

    input  logic                 lsb_valid,
    input  logic [ROB_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]          lsb_val,

    input  logic [ROB_WIDTH-1:0] search_rob_id_1,
    input  logic [ROB_WIDTH-1:0] search_rob_id_2,
    output logic                 search_ready_1,
    output logic                 search_ready_2,
    output logic [31:0]          search_val_1,
    output logic [31:0]          search_val_2,

    output logic                 commit_ready,
    output logic [4:0]           commit_reg_id,
    output logic [31:0]          commit_val,
    output logic [ROB_WIDTH-1:0] commit_rob_id,

    output logic                 store_commit,
    output logic [ROB_WIDTH-1:0] store_commit_rob_id,

    output logic [ROB_WIDTH-1:0] head_rob_id,
    output logic                 clear,
    output logic [31:0]          clear_pc,
    output logic                 halt
);

    logic [ROB_WIDTH-1:0] head_reg;
    logic [ROB_WIDTH-1:0] tail_reg;
    logic [ROB_WIDTH:0]   count_reg;
    logic [ROB_WIDTH:0]   count_next;
    logic [ROB_SIZE-1:0]  busy_reg;
    logic [ROB_SIZE-1:0]  ready_reg;
    rob_entry_t           entry_reg [ROB_SIZE];

    logic                 commit_ready_reg;
    logic [4:0]           commit_reg_id_reg;
    logic [31:0]          commit_val_reg;
    logic [ROB_WIDTH-1:0] commit_rob_id_reg;
    logic                 store_commit_reg;
    logic [ROB_WIDTH-1:0] store_commit_rob_id_reg;
    logic                 clear_reg;
    logic [31:0]          clear_pc_reg;
    logic                 halt_reg;

    logic [ROB_SIZE-1:0]  alu_hit;
    logic [ROB_SIZE-1:0]  lsb_hit;
    rob_entry_t           head_entry;
    logic                 do_commit;
    logic                 mispredict;

    assign head_entry = entry_reg[head_reg];
    assign do_commit  = busy_reg[head_reg] && ready_reg[head_reg] && !halt_reg;
    assign mispredict = (head_entry.kind == ROB_BRANCH) && (head_entry.jump != head_entry.pred_jump);

    // Writebacks only land on entries that are still in flight.
    generate
        for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : g_hit
            assign alu_hit[gi] = alu_valid && (alu_rob_id == ROB_WIDTH'(gi)) && busy_reg[gi];
            assign lsb_hit[gi] = lsb_valid && (lsb_rob_id == ROB_WIDTH'(gi)) && busy_reg[gi];
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (issue_valid && !do_commit) begin
            count_next = count_reg + 1'b1;
        end else if (!issue_valid && do_commit) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_reg                <= '0;
            tail_reg                <= '0;
            count_reg               <= '0;
            busy_reg                <= '0;
            ready_reg               <= '0;
            commit_ready_reg        <= 1'b0;
            commit_reg_id_reg       <= '0;
            commit_val_reg          <= '0;
            commit_rob_id_reg       <= '0;
            store_commit_reg        <= 1'b0;
            store_commit_rob_id_reg <= '0;
            clear_reg               <= 1'b0;
            clear_pc_reg            <= '0;
            halt_reg                <= 1'b0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                entry_reg[i] <= '0;
            end
        end else if (rdy_in) begin
            commit_ready_reg  <= 1'b0;
            commit_reg_id_reg <= '0;
            store_commit_reg  <= 1'b0;
            clear_reg         <= 1'b0;

            if (clear_reg) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
                busy_reg  <= '0;
                ready_reg <= '0;
            end else begin
                // ALU is applied after LSB so it wins if both name the same entry.
                for (int i = 0; i < ROB_SIZE; i++) begin
                    if (lsb_hit[i]) begin
                        ready_reg[i]     <= 1'b1;
                        entry_reg[i].val <= lsb_val;
                    end
                    if (alu_hit[i]) begin
                        ready_reg[i]        <= 1'b1;
                        entry_reg[i].val    <= alu_val;
                        entry_reg[i].jump   <= alu_jump;
                        entry_reg[i].target <= alu_target;
                    end
                end

                if (issue_valid) begin
                    entry_reg[tail_reg] <= '{kind: issue_type, rd: issue_rd, pc: issue_pc,
                                             val: issue_val, pred_jump: issue_pred_jump,
                                             jump: 1'b0, target: '0};
                    busy_reg[tail_reg]  <= 1'b1;
                    ready_reg[tail_reg] <= issue_done;
                    tail_reg            <= rob_next(tail_reg);
                end

                if (do_commit) begin
                    busy_reg[head_reg]  <= 1'b0;
                    ready_reg[head_reg] <= 1'b0;
                    head_reg            <= rob_next(head_reg);
                    commit_ready_reg    <= 1'b1;
                    commit_val_reg      <= head_entry.val;
                    commit_rob_id_reg   <= head_reg;
                    case (head_entry.kind)
                        ROB_REG: begin
                            commit_reg_id_reg <= head_entry.rd;
                        end
                        ROB_STORE: begin
                            store_commit_reg        <= 1'b1;
                            store_commit_rob_id_reg <= head_reg;
                        end
                        ROB_BRANCH: begin
                            // Link register is written even when the branch also redirects.
                            commit_reg_id_reg <= head_entry.rd;
                            if (mispredict) begin
                                clear_reg    <= 1'b1;
                                clear_pc_reg <= head_entry.jump ? head_entry.target : head_entry.pc + 32'd4;
                            end
                        end
                        default: begin
                            halt_reg <= 1'b1;
                        end
                    endcase
                end

                count_reg <= count_next;
            end
        end
    end

    // Dependency lookups: committed-ready entry first, then same-cycle ALU, then LSB.
    logic [ROB_WIDTH-1:0] search_id [2];
    logic [1:0]           search_rdy;
    logic [31:0]          search_v [2];

    assign search_id[0] = search_rob_id_1;
    assign search_id[1] = search_rob_id_2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_search
            logic entry_match;
            logic alu_match;
            logic lsb_match;
            assign entry_match    = busy_reg[search_id[gi]] && ready_reg[search_id[gi]];
            assign alu_match      = alu_valid && (alu_rob_id == search_id[gi]);
            assign lsb_match      = lsb_valid && (lsb_rob_id == search_id[gi]);
            assign search_rdy[gi] = entry_match || alu_match || lsb_match;
            assign search_v[gi]   = entry_match ? entry_reg[search_id[gi]].val :
                                    alu_match   ? alu_val :
                                    lsb_match   ? lsb_val : 32'd0;
        end
    endgenerate

    assign search_ready_1 = search_rdy[0];
    assign search_ready_2 = search_rdy[1];
    assign search_val_1   = search_v[0];
    assign search_val_2   = search_v[1];

    assign full                = (count_reg == (ROB_WIDTH+1)'(ROB_SIZE));
    assign issue_rob_id        = tail_reg;
    assign head_rob_id         = head_reg;
    assign commit_ready        = commit_ready_reg;
    assign commit_reg_id       = commit_reg_id_reg;
    assign commit_val          = commit_val_reg;
    assign commit_rob_id       = commit_rob_id_reg;
    assign store_commit        = store_commit_reg;
    assign store_commit_rob_id = store_commit_rob_id_reg;
    assign clear               = clear_reg;
    assign clear_pc            = clear_pc_reg;
    assign halt                = halt_reg;

endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer: retire order, wrap, mispredict flush, bypass search, store/halt.
module tb_rob;
    import rob_pkg::*;

    logic                 clk_in = 1'b0;
    logic                 rst_in, rdy_in;
    logic                 issue_valid, issue_pred_jump, issue_done;
    logic [1:0]           issue_type;
    logic [4:0]           issue_rd;
    logic [31:0]          issue_pc, issue_val;
    logic                 full;
    logic [ROB_WIDTH-1:0] issue_rob_id;
    logic                 alu_valid, alu_jump;
    logic [ROB_WIDTH-1:0] alu_rob_id;
    logic [31:0]          alu_val, alu_target;
    logic                 lsb_valid;
    logic [ROB_WIDTH-1:0] lsb_rob_id;
    logic [31:0]          lsb_val;
    logic [ROB_WIDTH-1:0] search_rob_id_1, search_rob_id_2;
    logic                 search_ready_1, search_ready_2;
    logic [31:0]          search_val_1, search_val_2;
    logic                 commit_ready;
    logic [4:0]           commit_reg_id;
    logic [31:0]          commit_val;
    logic [ROB_WIDTH-1:0] commit_rob_id;
    logic                 store_commit;
    logic [ROB_WIDTH-1:0] store_commit_rob_id;
    logic [ROB_WIDTH-1:0] head_rob_id;
    logic                 clear;
    logic [31:0]          clear_pc;
    logic                 halt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    rob dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd), .issue_pc(issue_pc),
        .issue_pred_jump(issue_pred_jump), .issue_done(issue_done), .issue_val(issue_val),
        .full(full), .issue_rob_id(issue_rob_id),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_val(alu_val),
        .alu_jump(alu_jump), .alu_target(alu_target),
        .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_val(lsb_val),
        .search_rob_id_1(search_rob_id_1), .search_rob_id_2(search_rob_id_2),
        .search_ready_1(search_ready_1), .search_ready_2(search_ready_2),
        .search_val_1(search_val_1), .search_val_2(search_val_2),
        .commit_ready(commit_ready), .commit_reg_id(commit_reg_id), .commit_val(commit_val),
        .commit_rob_id(commit_rob_id), .store_commit(store_commit), .store_commit_rob_id(store_commit_rob_id),
        .head_rob_id(head_rob_id), .clear(clear), .clear_pc(clear_pc), .halt(halt)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_type = ROB_REG; issue_rd = 0; issue_pc = 0;
        issue_pred_jump = 0; issue_done = 0; issue_val = 0;
        alu_valid = 0; alu_rob_id = 0; alu_val = 0; alu_jump = 0; alu_target = 0;
        lsb_valid = 0; lsb_rob_id = 0; lsb_val = 0;
        search_rob_id_1 = 0; search_rob_id_2 = 0;
        rdy_in = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 0;
        tick();
        tick();
        rst_in = 1;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                             input logic pj, input logic done, input logic [31:0] v);
        issue_valid = 1; issue_type = t; issue_rd = rd; issue_pc = pc;
        issue_pred_jump = pj; issue_done = done; issue_val = v;
    endtask

    task automatic issue_one(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                             input logic pj, input logic done, input logic [31:0] v);
        set_issue(t, rd, pc, pj, done, v);
        tick();
        issue_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %0d want 0", full); end
        vectors++; if (issue_rob_id !== 3'd0) begin miscompares++; $display("FAIL reset_tail: got %0d want 0", issue_rob_id); end
        vectors++; if (commit_ready !== 1'b0) begin miscompares++; $display("FAIL reset_commit_ready: got %0d want 0", commit_ready); end
        vectors++; if (commit_reg_id !== 5'd0) begin miscompares++; $display("FAIL reset_commit_reg_id: got %0d want 0", commit_reg_id); end
        vectors++; if (clear !== 1'b0) begin miscompares++; $display("FAIL reset_clear: got %0d want 0", clear); end
        vectors++; if (halt !== 1'b0) begin miscompares++; $display("FAIL reset_halt: got %0d want 0", halt); end
        $display("test_reset: outputs checked after two reset cycles");
    endtask

    task automatic test_in_order();
        do_reset();
        issue_one(ROB_REG, 5'd5, 32'h0, 0, 0, 0);
        issue_one(ROB_REG, 5'd6, 32'h4, 0, 0, 0);
        vectors++; if (issue_rob_id !== 3'd2) begin miscompares++; $display("FAIL inorder_tail: got %0d want 2", issue_rob_id); end
        alu_valid = 1; alu_rob_id = 3'd1; alu_val = 32'h22;
        tick();
        vectors++; if (commit_ready !== 1'b0) begin miscompares++; $display("FAIL inorder_wait1: got %0d want 0", commit_ready); end
        alu_rob_id = 3'd0; alu_val = 32'h11;
        tick();
        alu_valid = 0;
        vectors++; if (commit_ready !== 1'b0) begin miscompares++; $display("FAIL inorder_wait0: got %0d want 0", commit_ready); end
        tick();
        $display("commit: ready=%0d rd=%0d val=%h id=%0d", commit_ready, commit_reg_id, commit_val, commit_rob_id);
        vectors++; if ({commit_ready, commit_reg_id, commit_val, commit_rob_id} !== {1'b1, 5'd5, 32'h11, 3'd0}) begin
            miscompares++; $display("FAIL inorder_c0: got rdy=%0d rd=%0d val=%h id=%0d want 1/5/11/0", commit_ready, commit_reg_id, commit_val, commit_rob_id); end
        tick();
        $display("commit: ready=%0d rd=%0d val=%h id=%0d", commit_ready, commit_reg_id, commit_val, commit_rob_id);
        vectors++; if ({commit_ready, commit_reg_id, commit_val, commit_rob_id} !== {1'b1, 5'd6, 32'h22, 3'd1}) begin
            miscompares++; $display("FAIL inorder_c1: got rdy=%0d rd=%0d val=%h id=%0d want 1/6/22/1", commit_ready, commit_reg_id, commit_val, commit_rob_id); end
        tick();
        vectors++; if ({commit_ready, commit_reg_id} !== {1'b0, 5'd0}) begin
            miscompares++; $display("FAIL inorder_idle: got rdy=%0d rd=%0d want 0/0", commit_ready, commit_reg_id); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) issue_one(ROB_REG, 5'(10 + i), 32'(i * 4), 0, 0, 0);
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL wrap_full: got %0d want 1", full); end
        vectors++; if (issue_rob_id !== 3'd0) begin miscompares++; $display("FAIL wrap_tail: got %0d want 0", issue_rob_id); end
        alu_valid = 1; alu_rob_id = 3'd0; alu_val = 32'h100;
        tick();
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL wrap_full_ready: got %0d want 1", full); end
        for (int i = 1; i < 7; i++) begin
            alu_rob_id = 3'(i); alu_val = 32'h100 + 32'(i);
            tick();
            $display("commit: ready=%0d rd=%0d val=%h id=%0d", commit_ready, commit_reg_id, commit_val, commit_rob_id);
            vectors++; if ({commit_ready, commit_rob_id, commit_val} !== {1'b1, 3'(i - 1), 32'h100 + 32'(i - 1)}) begin
                miscompares++; $display("FAIL wrap_commit%0d: got rdy=%0d id=%0d val=%h", i - 1, commit_ready, commit_rob_id, commit_val); end
            if (i == 1) begin
                vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL wrap_full_after_commit: got %0d want 0", full); end
            end
        end
        alu_valid = 0;
        tick();
        vectors++; if ({head_rob_id, issue_rob_id} !== {3'd7, 3'd0}) begin
            miscompares++; $display("FAIL wrap_ptrs: got head=%0d tail=%0d want 7/0", head_rob_id, issue_rob_id); end
        alu_valid = 1; alu_rob_id = 3'd7; alu_val = 32'h777;
        tick();
        alu_valid = 0;
        set_issue(ROB_REG, 5'd20, 32'h80, 0, 0, 0);
        tick();
        issue_valid = 0;
        $display("commit: ready=%0d rd=%0d val=%h id=%0d", commit_ready, commit_reg_id, commit_val, commit_rob_id);
        vectors++; if ({commit_ready, commit_rob_id, commit_reg_id} !== {1'b1, 3'd7, 5'd17}) begin
            miscompares++; $display("FAIL wrap_commit7: got rdy=%0d id=%0d rd=%0d want 1/7/17", commit_ready, commit_rob_id, commit_reg_id); end
        vectors++; if ({head_rob_id, issue_rob_id, full} !== {3'd0, 3'd1, 1'b0}) begin
            miscompares++; $display("FAIL wrap_issue_commit: got head=%0d tail=%0d full=%0d want 0/1/0", head_rob_id, issue_rob_id, full); end
    endtask

    task automatic test_mispredict();
        do_reset();
        issue_one(ROB_BRANCH, 5'd1, 32'h100, 0, 0, 0);
        issue_one(ROB_REG, 5'd7, 32'h104, 0, 1, 32'h77);
        issue_one(ROB_REG, 5'd8, 32'h108, 0, 0, 0);
        alu_valid = 1; alu_rob_id = 3'd0; alu_val = 32'h104; alu_jump = 1; alu_target = 32'h200;
        tick();
        alu_valid = 0; alu_jump = 0;
        vectors++; if (clear !== 1'b0) begin miscompares++; $display("FAIL mp_early_clear: got %0d want 0", clear); end
        tick();
        $display("commit: ready=%0d rd=%0d val=%h clear=%0d clear_pc=%h", commit_ready, commit_reg_id, commit_val, clear, clear_pc);
        vectors++; if ({clear, clear_pc} !== {1'b1, 32'h200}) begin
            miscompares++; $display("FAIL mp_clear: got clear=%0d pc=%h want 1/200", clear, clear_pc); end
        vectors++; if ({commit_ready, commit_reg_id, commit_val} !== {1'b1, 5'd1, 32'h104}) begin
            miscompares++; $display("FAIL mp_link: got rdy=%0d rd=%0d val=%h want 1/1/104", commit_ready, commit_reg_id, commit_val); end
        set_issue(ROB_REG, 5'd9, 32'h200, 0, 1, 32'h99);
        alu_valid = 1; alu_rob_id = 3'd2; alu_val = 32'h88;
        tick();
        issue_valid = 0; alu_valid = 0;
        vectors++; if ({clear, commit_ready} !== 2'b00) begin
            miscompares++; $display("FAIL mp_after: got clear=%0d rdy=%0d want 0/0", clear, commit_ready); end
        vectors++; if ({head_rob_id, issue_rob_id, full} !== {3'd0, 3'd0, 1'b0}) begin
            miscompares++; $display("FAIL mp_flush: got head=%0d tail=%0d full=%0d want 0/0/0", head_rob_id, issue_rob_id, full); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (commit_ready !== 1'b0) begin
                miscompares++; $display("FAIL mp_no_commit%0d: got rdy=%0d rd=%0d want 0", i, commit_ready, commit_reg_id); end
        end
    endtask

    task automatic test_search_bypass();
        do_reset();
        for (int i = 0; i < 4; i++) issue_one(ROB_REG, 5'(i + 1), 32'(i * 4), 0, 0, 0);
        search_rob_id_1 = 3'd3; search_rob_id_2 = 3'd2;
        #1;
        vectors++; if ({search_ready_2, search_val_2} !== {1'b0, 32'h0}) begin
            miscompares++; $display("FAIL search_not_ready: got rdy=%0d val=%h want 0/0", search_ready_2, search_val_2); end
        alu_valid = 1; alu_rob_id = 3'd3; alu_val = 32'h7;
        lsb_valid = 1; lsb_rob_id = 3'd2; lsb_val = 32'h55;
        #1;
        $display("search: id3 rdy=%0d val=%h id2 rdy=%0d val=%h", search_ready_1, search_val_1, search_ready_2, search_val_2);
        vectors++; if ({search_ready_1, search_val_1} !== {1'b1, 32'h7}) begin
            miscompares++; $display("FAIL search_alu_bypass: got rdy=%0d val=%h want 1/7", search_ready_1, search_val_1); end
        vectors++; if ({search_ready_2, search_val_2} !== {1'b1, 32'h55}) begin
            miscompares++; $display("FAIL search_lsb_bypass: got rdy=%0d val=%h want 1/55", search_ready_2, search_val_2); end
        tick();
        alu_valid = 1; alu_rob_id = 3'd6; alu_val = 32'h66;
        lsb_valid = 0;
        tick();
        alu_valid = 0;
        search_rob_id_2 = 3'd6;
        #1;
        vectors++; if ({search_ready_1, search_val_1} !== {1'b1, 32'h7}) begin
            miscompares++; $display("FAIL search_entry: got rdy=%0d val=%h want 1/7", search_ready_1, search_val_1); end
        vectors++; if ({search_ready_2, search_val_2} !== {1'b0, 32'h0}) begin
            miscompares++; $display("FAIL search_nonbusy_wb: got rdy=%0d val=%h want 0/0", search_ready_2, search_val_2); end
        vectors++; if (commit_ready !== 1'b0) begin miscompares++; $display("FAIL search_no_commit: got %0d want 0", commit_ready); end
    endtask

    task automatic test_store_halt();
        do_reset();
        issue_one(ROB_STORE, 5'd0, 32'h40, 0, 0, 0);
        issue_one(ROB_HALT, 5'd0, 32'h44, 0, 1, 0);
        issue_one(ROB_REG, 5'd9, 32'h48, 0, 1, 32'h99);
        lsb_valid = 1; lsb_rob_id = 3'd0; lsb_val = 32'h1000;
        tick();
        lsb_valid = 0;
        vectors++; if (store_commit !== 1'b0) begin miscompares++; $display("FAIL st_early: got %0d want 0", store_commit); end
        tick();
        $display("commit: store=%0d id=%0d rd=%0d ready=%0d", store_commit, store_commit_rob_id, commit_reg_id, commit_ready);
        vectors++; if ({store_commit, store_commit_rob_id, commit_reg_id, commit_ready} !== {1'b1, 3'd0, 5'd0, 1'b1}) begin
            miscompares++; $display("FAIL st_commit: got st=%0d id=%0d rd=%0d rdy=%0d want 1/0/0/1", store_commit, store_commit_rob_id, commit_reg_id, commit_ready); end
        rdy_in = 0;
        tick();
        vectors++; if ({store_commit, halt, head_rob_id} !== {1'b1, 1'b0, 3'd1}) begin
            miscompares++; $display("FAIL pause_hold: got st=%0d halt=%0d head=%0d want 1/0/1", store_commit, halt, head_rob_id); end
        rdy_in = 1;
        tick();
        vectors++; if ({halt, store_commit, commit_reg_id} !== {1'b1, 1'b0, 5'd0}) begin
            miscompares++; $display("FAIL halt_commit: got halt=%0d st=%0d rd=%0d want 1/0/0", halt, store_commit, commit_reg_id); end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if ({halt, commit_ready, head_rob_id} !== {1'b1, 1'b0, 3'd2}) begin
                miscompares++; $display("FAIL halt_sticky%0d: got halt=%0d rdy=%0d head=%0d want 1/0/2", i, halt, commit_ready, head_rob_id); end
        end
    endtask

    initial begin
        rst_in = 0;
        idle_inputs();
        test_reset();
        test_in_order();
        test_full_wrap();
        test_mispredict();
        test_search_bypass();
        test_store_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
